// File: rtl/ae_reg_sequencer.sv
// ae_reg_sequencer: replays a sensor register table over an I2C write port
// whenever a new exposure/gain setting arrives, optionally aligned to the
// rising edge of the sensor frame sync. Failed writes are retried per entry;
// an entry that keeps failing aborts the burst with an error pulse.
module ae_reg_sequencer #(
  parameter int SYNC_VS   = 1,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 65535
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [15:0] I_ae,
  input  logic [15:0] I_ag,
  input  logic        I_update,
  input  logic        I_vsync,
  output logic [15:0] O_ae,
  output logic [15:0] O_ag,
  output logic [8:0]  O_reg_index,
  input  logic [31:0] I_reg_data,
  input  logic [8:0]  I_reg_size,
  output logic        O_wr_req,
  output logic [15:0] O_wr_addr,
  output logic [7:0]  O_wr_data,
  input  logic        I_wr_ack,
  input  logic        I_wr_done,
  input  logic        I_wr_err,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_err
);

  localparam int RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RETRY_MAX);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    LOAD,
    REQ,
    WAIT_DONE,
    NEXT
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              vs_q;
  logic              pend_q;
  logic [15:0]       pend_ae_q;
  logic [15:0]       pend_ag_q;
  logic [8:0]        idx_q;
  logic              last_q;
  logic [RTY_W-1:0]  rty_q;
  logic [TMO_W-1:0]  tmo_q;

  logic              load_en;
  logic              req_en;
  logic              acked;
  logic              wr_ok;
  logic              wr_fail;
  logic              retry_en;
  logic              done_set;
  logic              err_set;
  logic              tmo_hit;
  logic              last_entry;

  // Middle byte of a table entry carries no information for the write port.
  logic              unused_bits;
  assign unused_bits = ^I_reg_data[15:8];

  assign tmo_hit    = (tmo_q == TMO_LAST);
  // Clamped compare so the index can never run past the table end.
  assign last_entry = (idx_q >= (I_reg_size - 9'd1));

  assign O_busy      = (state_q != IDLE);
  assign O_reg_index = idx_q;

  // State register.
  always_ff @(posedge I_clk) begin
    if (I_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    req_en   = 1'b0;
    acked    = 1'b0;
    wr_ok    = 1'b0;
    wr_fail  = 1'b0;
    retry_en = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q || I_update) state_d = (SYNC_VS != 0) ? WAIT_VS : LOAD;
      end
      WAIT_VS: begin
        if (I_vsync && !vs_q) state_d = LOAD;
      end
      LOAD: begin
        load_en = 1'b1;
        if (I_reg_size == 9'd0) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end else begin
          req_en  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (I_wr_ack) begin
          acked   = 1'b1;
          state_d = WAIT_DONE;
        end else if (tmo_hit) begin
          wr_fail = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (I_wr_done && !I_wr_err) begin
          wr_ok   = 1'b1;
          state_d = NEXT;
        end else if (I_wr_done || tmo_hit) begin
          wr_fail = 1'b1;
        end
      end
      NEXT: begin
        if (last_q) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end else begin
          req_en  = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // A failed or timed-out write either retries the same entry or aborts.
    if (wr_fail) begin
      if (rty_q == RTY_LAST) begin
        err_set = 1'b1;
        state_d = IDLE;
      end else begin
        retry_en = 1'b1;
        req_en   = 1'b1;
        state_d  = REQ;
      end
    end
  end

  // Registered copy of vsync for rising-edge detection.
  always_ff @(posedge I_clk) begin
    if (I_rst) vs_q <= 1'b0;
    else       vs_q <= I_vsync;
  end

  // Pending setting: latest update wins; a same-cycle update survives LOAD.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pend_q <= 1'b0;
    end else if (I_update) begin
      pend_q    <= 1'b1;
      pend_ae_q <= I_ae;
      pend_ag_q <= I_ag;
    end else if (load_en) begin
      pend_q <= 1'b0;
    end
  end

  // Shadow exposure/gain, frozen for the whole burst.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_ae <= 16'd0;
      O_ag <= 16'd0;
    end else if (load_en) begin
      O_ae <= pend_ae_q;
      O_ag <= pend_ag_q;
    end
  end

  // Table index advances as a write completes, so the table output is
  // already settled for the next entry when NEXT re-enters REQ.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      idx_q  <= 9'd0;
      last_q <= 1'b0;
    end else if (load_en || done_set || err_set) begin
      idx_q  <= 9'd0;
      last_q <= 1'b0;
    end else if (wr_ok) begin
      last_q <= last_entry;
      if (!last_entry) idx_q <= idx_q + 9'd1;
    end
  end

  // Retry count for the current entry.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rty_q <= '0;
    end else if (load_en || wr_ok || err_set) begin
      rty_q <= '0;
    end else if (retry_en) begin
      rty_q <= rty_q + RTY_W'(1);
    end
  end

  // Timeout counter: restarts on every REQ entry, saturates at the limit.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      tmo_q <= '0;
    end else if (req_en) begin
      tmo_q <= '0;
    end else if ((state_q == REQ || state_q == WAIT_DONE) && !tmo_hit) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Write request port: captured on REQ entry, held until acknowledged.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_wr_req  <= 1'b0;
      O_wr_addr <= 16'd0;
      O_wr_data <= 8'd0;
    end else if (req_en) begin
      O_wr_req  <= 1'b1;
      O_wr_addr <= I_reg_data[31:16];
      O_wr_data <= I_reg_data[7:0];
    end else if (acked || err_set) begin
      O_wr_req  <= 1'b0;
    end
  end

  // Completion and abort pulses.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_done <= 1'b0;
      O_err  <= 1'b0;
    end else begin
      O_done <= done_set;
      O_err  <= err_set;
    end
  end

endmodule

// File: tb/tb_ae_reg_sequencer.sv
// Bench for ae_reg_sequencer: two instances (SYNC_VS=0 and SYNC_VS=1) driven
// by an I2C-master responder; observed writes are compared with a
// table/retry reference model.
module tb_ae_reg_sequencer;

  localparam int RMAX = 3;

  typedef struct {
    int          inst;
    int          idx;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] ae;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] ae_in = 16'd0;
  logic [15:0] ag_in = 16'd0;
  logic [1:0]  upd = 2'b00;
  logic        vs_man = 1'b0;
  logic        vs_gen = 1'b0;
  logic        vs_auto = 1'b0;
  logic        vsync;
  logic        spur = 1'b0;
  logic [8:0]  reg_size = 9'd0;
  logic [31:0] table_mem [16];
  int          fail_plan [16];
  int          ack_dly = 0;
  int          done_dly = 0;

  logic [1:0][15:0] o_ae, o_ag, wr_addr;
  logic [1:0][8:0]  o_idx;
  logic [1:0][7:0]  wr_data;
  logic [1:0][31:0] reg_data;
  logic [1:0]       wr_req, busy, done, err;
  logic [1:0]       r_ack = 2'b00, r_done = 2'b00, r_err = 2'b00;

  assign vsync = vs_man | vs_gen;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    assign reg_data[g] = table_mem[o_idx[g][3:0]];
    ae_reg_sequencer #(.SYNC_VS(g), .RETRY_MAX(RMAX), .TIMEOUT(65535)) u_dut (
      .I_clk       (clk),
      .I_rst       (rst),
      .I_ae        (ae_in),
      .I_ag        (ag_in),
      .I_update    (upd[g]),
      .I_vsync     (vsync),
      .O_ae        (o_ae[g]),
      .O_ag        (o_ag[g]),
      .O_reg_index (o_idx[g]),
      .I_reg_data  (reg_data[g]),
      .I_reg_size  (reg_size),
      .O_wr_req    (wr_req[g]),
      .O_wr_addr   (wr_addr[g]),
      .O_wr_data   (wr_data[g]),
      .I_wr_ack    (r_ack[g] | spur),
      .I_wr_done   (r_done[g] | spur),
      .I_wr_err    (r_err[g]),
      .O_busy      (busy[g]),
      .O_done      (done[g]),
      .O_err       (err[g])
    );
  end

  // Responder / monitor state (written only by the always block below)
  int          ph [2];
  int          cnt [2];
  int          att [2];
  int          cur_idx [2];
  int          last_idx [2];
  int          done_cnt [2];
  int          err_cnt [2];
  int          req_cyc [2];
  int          hold_bad [2];
  logic [15:0] h_addr [2];
  logic [7:0]  h_data [2];
  int          vs_tick = 0;
  wr_t         wlog [$];

  // I2C master model: acks after ack_dly, ends after done_dly, NACKs the
  // first fail_plan[idx] attempts on each entry of a burst.
  always @(negedge clk) begin
    vs_tick++;
    vs_gen = vs_auto && ((vs_tick % 37) < 2);
    for (int g = 0; g < 2; g++) begin
      r_ack[g]  = 1'b0;
      r_done[g] = 1'b0;
      r_err[g]  = 1'b0;
      if (rst) begin
        ph[g] = 0;
      end else begin
        if (done[g] === 1'b1) done_cnt[g]++;
        if (err[g] === 1'b1) err_cnt[g]++;
        if (wr_req[g] === 1'b1) req_cyc[g]++;
        if (busy[g] === 1'b0) last_idx[g] = -1;
        if (ph[g] == 0 && wr_req[g] === 1'b1) begin
          ph[g] = 1;
          cnt[g] = ack_dly;
          h_addr[g] = wr_addr[g];
          h_data[g] = wr_data[g];
        end
        if (ph[g] == 1) begin
          if (wr_req[g] !== 1'b1 || wr_addr[g] !== h_addr[g] || wr_data[g] !== h_data[g])
            hold_bad[g]++;
          if (cnt[g] == 0) begin
            r_ack[g] = 1'b1;
            cur_idx[g] = int'(o_idx[g]);
            att[g] = (cur_idx[g] == last_idx[g]) ? att[g] + 1 : 1;
            last_idx[g] = cur_idx[g];
            wlog.push_back('{g, cur_idx[g], wr_addr[g], wr_data[g], o_ae[g]});
            ph[g] = 2;
            cnt[g] = done_dly;
          end else begin
            cnt[g]--;
          end
        end else if (ph[g] == 2) begin
          if (cnt[g] == 0) begin
            r_done[g] = 1'b1;
            r_err[g]  = (att[g] <= fail_plan[cur_idx[g] % 16]);
            ph[g] = 0;
          end else begin
            cnt[g]--;
          end
        end
      end
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   rd_ptr = 0;
  wr_t  exp_q [$];
  int   exp_done = 0;
  int   exp_err = 0;
  int   base_done, base_err, base_hold, base_req;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_update(input int g, input logic [15:0] ae, input logic [15:0] ag);
    ae_in = ae;
    ag_in = ag;
    upd[g] = 1'b1;
    tick(1);
    upd = 2'b00;
  endtask

  task automatic new_table(input int size);
    reg_size = 9'(size);
    for (int i = 0; i < 16; i++) begin
      table_mem[i] = $urandom;
      fail_plan[i] = 0;
    end
  endtask

  // Reference: every entry is written once plus once per NACK, up to
  // RMAX retries; exhausting them aborts the burst.
  function automatic void model_burst(input int g, input int size, input logic [15:0] ae);
    int tries;
    if (size == 0) begin
      exp_done++;
      return;
    end
    for (int i = 0; i < size; i++) begin
      tries = (fail_plan[i] > RMAX) ? RMAX + 1 : fail_plan[i] + 1;
      for (int a = 0; a < tries; a++)
        exp_q.push_back('{g, i, table_mem[i][31:16], table_mem[i][7:0], ae});
      if (fail_plan[i] > RMAX) begin
        exp_err++;
        return;
      end
    end
    exp_done++;
  endfunction

  task automatic snap(input int g);
    base_done = done_cnt[g];
    base_err  = err_cnt[g];
    base_hold = hold_bad[g];
    base_req  = req_cyc[g];
    rd_ptr    = wlog.size();
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
  endtask

  task automatic wait_quiet(input string tag, input int g);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 6000) begin
      tick(1);
      n++;
      quiet = (busy[g] === 1'b0) ? quiet + 1 : 0;
    end
    chk({tag, "_settled"}, quiet >= 3, 1);
  endtask

  task automatic finish_scn(input string tag, input int g);
    int n_got;
    int n_exp;
    wait_quiet(tag, g);
    n_got = wlog.size() - rd_ptr;
    n_exp = exp_q.size();
    chk({tag, "_writes"}, n_got, n_exp);
    for (int k = 0; k < n_exp && k < n_got; k++) begin
      wr_t a;
      wr_t e;
      a = wlog[rd_ptr + k];
      e = exp_q[k];
      chk($sformatf("%s_w%0d_inst", tag, k), a.inst, e.inst);
      chk($sformatf("%s_w%0d_idx", tag, k), a.idx, e.idx);
      chk($sformatf("%s_w%0d_addr", tag, k), a.addr, e.addr);
      chk($sformatf("%s_w%0d_data", tag, k), a.data, e.data);
      chk($sformatf("%s_w%0d_ae", tag, k), a.ae, e.ae);
    end
    chk({tag, "_done"}, done_cnt[g] - base_done, exp_done);
    chk({tag, "_err"}, err_cnt[g] - base_err, exp_err);
    chk({tag, "_hold"}, hold_bad[g] - base_hold, 0);
  endtask

  task automatic chk_zero(input string tag, input int g);
    chk({tag, "_busy"}, busy[g], 0);
    chk({tag, "_wr_req"}, wr_req[g], 0);
    chk({tag, "_done"}, done[g], 0);
    chk({tag, "_err"}, err[g], 0);
    chk({tag, "_ae"}, o_ae[g], 0);
    chk({tag, "_ag"}, o_ag[g], 0);
    chk({tag, "_idx"}, o_idx[g], 0);
    chk({tag, "_addr"}, wr_addr[g], 0);
    chk({tag, "_data"}, wr_data[g], 0);
  endtask

  initial begin
    int n;
    int g;
    int size;
    int r;
    logic [15:0] ae_r;
    int log_mark;

    // Reset state of both instances
    new_table(0);
    tick(3);
    chk_zero("rst0", 0);
    chk_zero("rst1", 1);
    rst = 1'b0;
    tick(2);
    chk("post_rst_busy0", busy[0], 0);
    chk("post_rst_busy1", busy[1], 0);

    // Immediate burst: five writes in order, one done pulse
    new_table(5);
    ack_dly = 0;
    done_dly = 9;
    snap(0);
    model_burst(0, 5, 16'h1234);
    pulse_update(0, 16'h1234, 16'h0080);
    finish_scn("imm5", 0);
    chk("imm5_ae", o_ae[0], 16'h1234);
    chk("imm5_ag", o_ag[0], 16'h0080);

    // Frame-synchronised start: nothing until two cycles after the edge
    new_table(3);
    ack_dly = 1;
    done_dly = 3;
    snap(1);
    model_burst(1, 3, 16'h4321);
    pulse_update(1, 16'h4321, 16'h0011);
    tick(100);
    chk("vs_wait_req", req_cyc[1] - base_req, 0);
    chk("vs_wait_busy", busy[1], 1);
    vs_man = 1'b1;
    tick(1);
    chk("vs_edge_plus1_req", wr_req[1], 0);
    tick(1);
    chk("vs_edge_plus2_req", wr_req[1], 1);
    vs_man = 1'b0;
    finish_scn("vs3", 1);

    // Two NACKs on entry 2, then success
    new_table(4);
    fail_plan[2] = 2;
    ack_dly = 2;
    done_dly = 4;
    snap(0);
    model_burst(0, 4, 16'h0042);
    pulse_update(0, 16'h0042, 16'h0001);
    finish_scn("retry2", 0);

    // Persistent NACK on entry 1: four attempts then abort
    new_table(3);
    fail_plan[1] = 50;
    ack_dly = 0;
    done_dly = 2;
    snap(0);
    model_burst(0, 3, 16'h0043);
    pulse_update(0, 16'h0043, 16'h0002);
    finish_scn("abort", 0);
    chk("abort_wr_req", wr_req[0], 0);

    // Updates during a burst: shadow frozen, latest value used afterwards
    new_table(4);
    ack_dly = 1;
    done_dly = 5;
    snap(0);
    model_burst(0, 4, 16'h0050);
    model_burst(0, 4, 16'h0200);
    pulse_update(0, 16'h0050, 16'h0005);
    tick(8);
    pulse_update(0, 16'h0100, 16'h0006);
    tick(5);
    pulse_update(0, 16'h0200, 16'h0007);
    chk("midburst_ae_frozen", o_ae[0], 16'h0050);
    finish_scn("latest", 0);
    chk("latest_ae", o_ae[0], 16'h0200);
    chk("latest_ag", o_ag[0], 16'h0007);

    // Update in the same cycle as the done pulse starts another burst
    new_table(2);
    ack_dly = 0;
    done_dly = 1;
    snap(0);
    model_burst(0, 2, 16'h0011);
    model_burst(0, 2, 16'h0777);
    pulse_update(0, 16'h0011, 16'h0000);
    n = 0;
    while (done[0] !== 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    chk("done_seen", n < 500, 1);
    pulse_update(0, 16'h0777, 16'h0000);
    finish_scn("upd_at_done", 0);
    chk("upd_at_done_ae", o_ae[0], 16'h0777);

    // Empty table: done pulse, no request
    new_table(0);
    snap(0);
    model_burst(0, 0, 16'h0099);
    pulse_update(0, 16'h0099, 16'h0000);
    finish_scn("empty", 0);
    chk("empty_req_cycles", req_cyc[0] - base_req, 0);

    // Stray ack/done while idle are ignored
    snap(0);
    spur = 1'b1;
    tick(3);
    spur = 1'b0;
    tick(2);
    chk("stray_busy0", busy[0], 0);
    chk("stray_busy1", busy[1], 0);
    chk("stray_req0", wr_req[0], 0);
    chk("stray_done0", done_cnt[0] - base_done, 0);
    chk("stray_err0", err_cnt[0] - base_err, 0);

    // Reset while waiting for the transaction to end
    new_table(3);
    ack_dly = 0;
    done_dly = 30;
    snap(0);
    pulse_update(0, 16'hABCD, 16'h1357);
    n = 0;
    while (ph[0] != 2 && n < 500) begin
      tick(1);
      n++;
    end
    chk("rst_mid_reached", n < 500, 1);
    rst = 1'b1;
    tick(1);
    chk_zero("rst_mid", 0);
    rst = 1'b0;
    log_mark = wlog.size();
    tick(40);
    chk("rst_mid_idle", busy[0], 0);
    chk("rst_mid_no_resume", wlog.size() - log_mark, 0);
    chk("rst_mid_no_done", done_cnt[0] - base_done, 0);

    // Randomised bursts on both instances
    for (int it = 0; it < 12; it++) begin
      g = $urandom_range(0, 1);
      size = $urandom_range(1, 8);
      new_table(size);
      for (int i = 0; i < size; i++) begin
        r = $urandom_range(0, 9);
        fail_plan[i] = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 20;
      end
      ack_dly = $urandom_range(0, 3);
      done_dly = $urandom_range(0, 6);
      vs_auto = (g == 1);
      ae_r = 16'($urandom);
      snap(g);
      model_burst(g, size, ae_r);
      pulse_update(g, ae_r, 16'($urandom));
      finish_scn($sformatf("rnd%0d", it), g);
      chk($sformatf("rnd%0d_ae", it), o_ae[g], ae_r);
    end
    vs_auto = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ae_reg_sequencer.md
AE_REG_SEQUENCER -- requirements
Module: ae_reg_sequencer

Interface
REQ-001 Parameter SYNC_VS, default 1: 1 = burst starts on next I_vsync rising edge; 0 = burst starts immediately.
REQ-002 Parameter RETRY_MAX, default 3: retries per register after a failed write.
REQ-003 Parameter TIMEOUT, default 65535: cycles allowed from request to I_wr_done.
REQ-004 I_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 I_rst  in  1  synchronous, active-high reset.
REQ-006 I_ae / I_ag  in  16 / 16  requested exposure / analog gain.
REQ-007 I_update  in  1  one-cycle pulse; samples I_ae/I_ag as a new setting.
REQ-008 I_vsync  in  1  sensor frame sync, already synchronous to I_clk.
REQ-009 O_ae / O_ag  out  16 / 16  shadow values driving the register table; stable for a whole burst.
REQ-010 O_reg_index  out  9  table index; I_reg_data  in  32  {addr[31:16], data[7:0]}; I_reg_size  in  9  entry count.
REQ-011 O_wr_req  out  1; O_wr_addr  out  16; O_wr_data  out  8: write request to the I2C master.
REQ-012 I_wr_ack  in  1  master accepted the request; I_wr_done  in  1  transaction-end pulse; I_wr_err  in  1  NACK, valid with I_wr_done.
REQ-013 O_busy  out  1; O_done  out  1  one-cycle pulse; O_err  out  1  one-cycle pulse at abort.

Function
REQ-014 States SHALL be IDLE, WAIT_VS, LOAD, REQ, WAIT_DONE, NEXT.
REQ-015 IDLE + I_update (or pending flag set) SHALL go to WAIT_VS when SYNC_VS=1, else to LOAD.
REQ-016 WAIT_VS SHALL go to LOAD on the cycle I_vsync is 1 while its registered copy is 0.
REQ-017 LOAD SHALL copy the pending values to O_ae/O_ag, clear pending, and set index 0.
REQ-018 LOAD SHALL go to NEXT-check: if I_reg_size==0 it pulses O_done and returns to IDLE with no write.
REQ-019 LOAD SHALL otherwise go to REQ.
REQ-020 Entering REQ SHALL register O_wr_addr=I_reg_data[31:16], O_wr_data=I_reg_data[7:0], and assert O_wr_req.
REQ-021 O_wr_req, O_wr_addr and O_wr_data SHALL hold stable until the cycle I_wr_ack is sampled 1.
REQ-022 O_wr_req SHALL deassert on the following cycle, and the state SHALL move to WAIT_DONE.
REQ-023 The timeout counter SHALL start at REQ entry and increment every cycle in REQ/WAIT_DONE.
REQ-024 I_wr_done with I_wr_err=0 SHALL clear the retry count and go to NEXT.
REQ-025 I_wr_done with I_wr_err=1, or the counter reaching TIMEOUT, SHALL re-enter REQ for the same index while retries < RETRY_MAX.
REQ-026 When retries == RETRY_MAX on such a failure, the block SHALL pulse O_err, drop the burst and return to IDLE.
REQ-027 NEXT SHALL increment the index; if index == I_reg_size-1, it SHALL pulse O_done and go to IDLE, else go to REQ.
REQ-028 An I_update in any state SHALL store I_ae/I_ag in pending registers and set the pending flag; latest wins.
REQ-029 A pending update arriving during a burst SHALL NOT change O_ae/O_ag until the next LOAD.
REQ-030 I_update in the same cycle as O_done SHALL leave pending set, so IDLE starts a new burst the next cycle.
REQ-031 O_busy SHALL be 1 in every state except IDLE.
REQ-032 I_wr_ack or I_wr_done outside REQ/WAIT_DONE SHALL be ignored.
REQ-033 Index and retry widths: index 9 bits, retry count ceil(log2(RETRY_MAX+1)) bits, no wrap beyond I_reg_size.

Reset
REQ-034 I_rst SHALL force IDLE and clear the pending flag, index and counters.
REQ-035 I_rst SHALL force O_ae/O_ag to 0, O_reg_index to 0, and all other outputs to 0.
REQ-036 Reset asserted mid-burst SHALL drop O_wr_req the next cycle; writes not yet completed are not resumed.

Verification
REQ-037 SYNC_VS=0, size=5, I_ae=16'h1234, I_ag=16'h0080, master acks in 1 cycle and completes after 10 cycles -> five writes in order, indexes 0..4, then one O_done pulse.
REQ-038 SYNC_VS=1, I_update then I_vsync rising 100 cycles later -> O_wr_req stays 0 until 2 cycles after the edge.
REQ-039 I_wr_err=1 on index 2 twice, then success -> index 2 written 3 times, O_err=0, O_done=1.
REQ-040 I_wr_err persistent on index 1, RETRY_MAX=3 -> 4 attempts, one O_err pulse, no O_done.
REQ-041 Two I_update pulses (ae=0x100, then ae=0x200) during a burst -> after O_done, one further burst with O_ae=0x200.
REQ-042 I_reg_size=0 -> O_done pulse, O_wr_req never asserted; I_rst during WAIT_DONE -> IDLE with all outputs 0.
